// File: rtl/jtframe_rstseq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jtframe_rstseq_pkg                                            |
// | Purpose  : Shared definitions for the PLL reset sequencer: counter width, |
// |            state encoding and a terminal-count helper.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package jtframe_rstseq_pkg;

  localparam int CNT_W = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_PLLRST = 3'd0;
  localparam state_t ST_WAITLK = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_RELSD  = 3'd3;
  localparam state_t ST_RELVID = 3'd4;
  localparam state_t ST_RUN    = 3'd5;
  localparam state_t ST_FAIL   = 3'd6;

  // Counter value seen on the last cycle of an n-cycle interval.
  function automatic logic [CNT_W-1:0] tc(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_sync2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jtframe_sync2                                                 |
// | Purpose  : Two-flop synchroniser for a single asynchronous level.        |
// | Ports    : clk - destination clock                                       |
// |            rst - asynchronous active-high reset (output resets to 0)     |
// |            d   - asynchronous input                                      |
// |            q   - synchronised output, two cycles behind d                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module jtframe_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= d;
      ff2_q <= ff1_q;
    end
  end

  assign q = ff2_q;

endmodule
`default_nettype wire

// File: rtl/jtframe_pll_rst_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jtframe_pll_rst_seq                                           |
// | Purpose  : Power-up / lock supervisor for the base+game PLL pair. Holds  |
// |            the PLLs in reset, waits for a stable lock, then releases the |
// |            SDRAM, video and game domain resets in that order. Lock loss  |
// |            restarts the whole sequence.                                  |
// | Ports    : clk, rst (async, active high)                                 |
// |            pll_locked, game_rst      - asynchronous inputs               |
// |            pll_rst                   - reset to both PLLs                |
// |            rst_sdram/video/game      - domain reset requests             |
// |            ready (RUN), fail (FAIL), retries (failed lock attempts)      |
// | Options  : JTFRAME_PLL_WATCHDOG_EN - enables the lock watchdog, retry    |
// |            counting and the terminal FAIL state.                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module jtframe_pll_rst_seq
  import jtframe_rstseq_pkg::*;
#(
  parameter int unsigned RSTW     = 16,
  parameter int unsigned SETTLE   = 1024,
  parameter int unsigned STAGE    = 64,
  parameter int unsigned LOCKTO   = 65535,
  parameter int unsigned MAXRETRY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       game_rst,
  output logic       pll_rst,
  output logic       rst_sdram,
  output logic       rst_video,
  output logic       rst_game,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retries
);

  localparam logic [CNT_W-1:0] RSTW_TC   = tc(RSTW);
  localparam logic [CNT_W-1:0] SETTLE_TC = tc(SETTLE);
  localparam logic [CNT_W-1:0] STAGE_TC  = tc(STAGE);
  localparam logic [CNT_W-1:0] STAGE_LD  = CNT_W'(STAGE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Out-of-range parameters have no defined behaviour; refuse to elaborate.
  if (RSTW < 1 || RSTW > 65535 || SETTLE < 1 || SETTLE > 65535 ||
      STAGE < 1 || STAGE > 65535 || LOCKTO < 1 || LOCKTO > 65535 ||
      MAXRETRY < 1 || MAXRETRY > 15) begin : g_param_check
    $error("jtframe_pll_rst_seq: parameter out of range");
  end

  logic lock_s;
  logic grst_s;

  jtframe_sync2 u_sync_lock (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  jtframe_sync2 u_sync_grst (
    .clk (clk),
    .rst (rst),
    .d   (game_rst),
    .q   (grst_s)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Game-reset stretch: cycles still to hold rst_game after grst_s falls.
  logic [CNT_W-1:0] str_q, str_d;
  logic             pll_rst_q, pll_rst_d;
  logic             rst_sdram_q, rst_sdram_d;
  logic             rst_video_q, rst_video_d;
  logic             rst_game_q, rst_game_d;
  logic             ready_q, ready_d;

`ifdef JTFRAME_PLL_WATCHDOG_EN
  localparam logic [CNT_W-1:0] LOCKTO_TC  = tc(LOCKTO);
  localparam logic [3:0]       MAXRETRY_C = 4'(MAXRETRY);
  logic [3:0] retries_q, retries_d;
  logic       fail_q, fail_d;
`endif

  always_comb begin
    state_d = state_q;
`ifdef JTFRAME_PLL_WATCHDOG_EN
    retries_d = retries_q;
`endif
    // Lock loss is tested first in every released state so it wins over
    // terminal counts and game-reset activity.
    case (state_q)
      ST_PLLRST: if (cnt_q == RSTW_TC) state_d = ST_WAITLK;
      ST_WAITLK: begin
        if (lock_s) begin
          state_d = ST_SETTLE;
        end
`ifdef JTFRAME_PLL_WATCHDOG_EN
        else if (cnt_q == LOCKTO_TC) begin
          retries_d = (retries_q == 4'd15) ? 4'd15 : retries_q + 4'd1;
          state_d   = (retries_d == MAXRETRY_C) ? ST_FAIL : ST_PLLRST;
        end
`endif
      end
      ST_SETTLE: begin
        // A glitch while settling just restarts the wait; not a retry.
        if (!lock_s)                 state_d = ST_WAITLK;
        else if (cnt_q == SETTLE_TC) state_d = ST_RELSD;
      end
      ST_RELSD: begin
        if (!lock_s)                state_d = ST_PLLRST;
        else if (cnt_q == STAGE_TC) state_d = ST_RELVID;
      end
      ST_RELVID: begin
        if (!lock_s)                state_d = ST_PLLRST;
        else if (cnt_q == STAGE_TC) state_d = ST_RUN;
      end
      ST_RUN: if (!lock_s) state_d = ST_PLLRST;
`ifdef JTFRAME_PLL_WATCHDOG_EN
      ST_FAIL: state_d = ST_FAIL;
`endif
      default: state_d = ST_PLLRST;
    endcase

    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_ONE;

    // Outputs are registered from the next state so that they change on the
    // same edge as the state itself.
    pll_rst_d   = (state_d == ST_PLLRST) || (state_d == ST_FAIL);
    rst_sdram_d = !(state_d inside {ST_RELSD, ST_RELVID, ST_RUN});
    rst_video_d = !(state_d inside {ST_RELVID, ST_RUN});
    ready_d     = (state_d == ST_RUN);

    // The stretch only runs inside RUN; it is zero on RUN entry so rst_game
    // drops on the entry edge unless grst_s is already high.
    str_d      = '0;
    rst_game_d = 1'b1;
    if (state_d == ST_RUN) begin
      if (grst_s)           str_d = STAGE_LD;
      else if (str_q != '0) str_d = str_q - CNT_ONE;
      rst_game_d = grst_s || (str_q != '0);
    end

`ifdef JTFRAME_PLL_WATCHDOG_EN
    fail_d = (state_d == ST_FAIL);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PLLRST;
      cnt_q       <= '0;
      str_q       <= '0;
      pll_rst_q   <= 1'b1;
      rst_sdram_q <= 1'b1;
      rst_video_q <= 1'b1;
      rst_game_q  <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      str_q       <= str_d;
      pll_rst_q   <= pll_rst_d;
      rst_sdram_q <= rst_sdram_d;
      rst_video_q <= rst_video_d;
      rst_game_q  <= rst_game_d;
      ready_q     <= ready_d;
    end
  end

`ifdef JTFRAME_PLL_WATCHDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retries_q <= 4'd0;
      fail_q    <= 1'b0;
    end else begin
      retries_q <= retries_d;
      fail_q    <= fail_d;
    end
  end

  assign retries = retries_q;
  assign fail    = fail_q;
`else
  assign retries = 4'd0;
  assign fail    = 1'b0;
`endif

  assign pll_rst   = pll_rst_q;
  assign rst_sdram = rst_sdram_q;
  assign rst_video = rst_video_q;
  assign rst_game  = rst_game_q;
  assign ready     = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_pll_rst_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_jtframe_pll_rst_seq                                        |
// | Purpose  : Self-checking bench for jtframe_pll_rst_seq: directed power-up,|
// |            game-reset, lock-loss and watchdog scenarios plus randomized  |
// |            lock/game-reset traffic against a time-based reference model. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_jtframe_pll_rst_seq;

  localparam int RSTW     = 16;
  localparam int SETTLE   = 1024;
  localparam int STAGE    = 64;
  localparam int LOCKTO   = 100;
  localparam int MAXRETRY = 3;
`ifdef JTFRAME_PLL_WATCHDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  // Model phases, ordered so that "released" can be tested by range.
  localparam int P_PLLRST = 0, P_WAIT = 1, P_SETTLE = 2, P_RELSD = 3,
                 P_RELVID = 4, P_RUN = 5, P_FAIL = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       game_rst = 1'b0;
  logic       pll_rst, rst_sdram, rst_video, rst_game, ready, fail;
  logic [3:0] retries;

  jtframe_pll_rst_seq #(
    .RSTW     (RSTW),
    .SETTLE   (SETTLE),
    .STAGE    (STAGE),
    .LOCKTO   (LOCKTO),
    .MAXRETRY (MAXRETRY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .game_rst   (game_rst),
    .pll_rst    (pll_rst),
    .rst_sdram  (rst_sdram),
    .rst_video  (rst_video),
    .rst_game   (rst_game),
    .ready      (ready),
    .fail       (fail),
    .retries    (retries)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;          // edges since the last rst release

  // Reference model: current phase, cycles spent in it, retry total, the
  // last edge at which the synchronised game reset was seen high in RUN,
  // and the two-deep delay of each asynchronous input.
  int m_ph, m_t, m_retr, m_lasthi;
  bit m_lk1, m_lk2, m_gr1, m_gr2;

  // Observed output edges (edge index, -1 = not seen since reset).
  int ev_pll_fall, ev_pll_rise, ev_sd_fall, ev_vid_fall;
  int ev_rdy_rise, ev_rdy_fall, ev_fail_rise, ev_game_rise, ev_game_fall;
  int ev_retry [16];
  logic p_pll, p_sd, p_vid, p_game, p_rdy, p_fail;
  logic [3:0] p_retr;

  int t_mark;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", nm, cyc, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_ph = P_PLLRST; m_t = 0; m_retr = 0; m_lasthi = -1000000;
    m_lk1 = 0; m_lk2 = 0; m_gr1 = 0; m_gr2 = 0;
    cyc = 0;
    ev_pll_fall = -1; ev_pll_rise = -1; ev_sd_fall = -1; ev_vid_fall = -1;
    ev_rdy_rise = -1; ev_rdy_fall = -1; ev_fail_rise = -1;
    ev_game_rise = -1; ev_game_fall = -1;
    for (int k = 0; k < 16; k++) ev_retry[k] = -1;
    p_pll = 1; p_sd = 1; p_vid = 1; p_game = 1; p_rdy = 0; p_fail = 0; p_retr = 0;
  endtask

  task automatic model_edge();
    bit ls, gs;
    int nph;
    ls  = m_lk2;
    gs  = m_gr2;
    nph = m_ph;
    cyc++;
    case (m_ph)
      P_PLLRST: if (m_t == RSTW - 1) nph = P_WAIT;
      P_WAIT: begin
        if (ls) nph = P_SETTLE;
        else if (WDOG && m_t == LOCKTO - 1) begin
          m_retr = (m_retr < 15) ? m_retr + 1 : 15;
          nph = (m_retr == MAXRETRY) ? P_FAIL : P_PLLRST;
        end
      end
      P_SETTLE: if (!ls) nph = P_WAIT; else if (m_t == SETTLE - 1) nph = P_RELSD;
      P_RELSD, P_RELVID: if (!ls) nph = P_PLLRST; else if (m_t == STAGE - 1) nph = m_ph + 1;
      P_RUN: if (!ls) nph = P_PLLRST;
      default: nph = m_ph;
    endcase
    m_t  = (nph == m_ph) ? m_t + 1 : 0;
    m_ph = nph;
    if (m_ph != P_RUN) m_lasthi = -1000000;
    else if (gs)       m_lasthi = cyc;
    m_lk2 = m_lk1; m_lk1 = pll_locked;
    m_gr2 = m_gr1; m_gr1 = game_rst;
  endtask

  task automatic compare_all();
    chk("pll_rst",   int'(pll_rst),   int'(m_ph == P_PLLRST || m_ph == P_FAIL));
    chk("rst_sdram", int'(rst_sdram), int'(!(m_ph >= P_RELSD && m_ph <= P_RUN)));
    chk("rst_video", int'(rst_video), int'(!(m_ph >= P_RELVID && m_ph <= P_RUN)));
    chk("rst_game",  int'(rst_game),  int'(m_ph != P_RUN || (cyc - m_lasthi) <= STAGE));
    chk("ready",     int'(ready),     int'(m_ph == P_RUN));
    chk("fail",      int'(fail),      int'(m_ph == P_FAIL));
    chk("retries",   int'(retries),   m_retr);
    chk("order_sdram_vs_pll", int'(!rst_sdram && pll_rst),   0);
    chk("order_video_vs_sdram", int'(!rst_video && rst_sdram), 0);
    chk("order_game_vs_video", int'(!rst_game && rst_video),  0);
  endtask

  task automatic record_events();
    if (p_pll && !pll_rst)    ev_pll_fall  = cyc;
    if (!p_pll && pll_rst)    ev_pll_rise  = cyc;
    if (p_sd && !rst_sdram)   ev_sd_fall   = cyc;
    if (p_vid && !rst_video)  ev_vid_fall  = cyc;
    if (!p_rdy && ready)      ev_rdy_rise  = cyc;
    if (p_rdy && !ready)      ev_rdy_fall  = cyc;
    if (!p_game && rst_game)  ev_game_rise = cyc;
    if (p_game && !rst_game)  ev_game_fall = cyc;
    if (!p_fail && fail)      ev_fail_rise = cyc;
    if (retries != p_retr)    ev_retry[retries] = cyc;
    p_pll = pll_rst; p_sd = rst_sdram; p_vid = rst_video; p_game = rst_game;
    p_rdy = ready; p_fail = fail; p_retr = retries;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    compare_all();
    record_events();
  endtask

  // Assert rst between edges: outputs must reset without waiting for a clock.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();

    // Reset state
    step();
    step();
    chk("reset_pll_rst", int'(pll_rst), 1);
    chk("reset_ready", int'(ready), 0);
    chk("reset_retries", int'(retries), 0);
    rst = 1'b0;

    // Power-up: lock appears after edge 100
    for (int i = 0; i < 100; i++) step();
    pll_locked = 1'b1;
    for (int i = 0; i < 3000 && !ready; i++) step();
    chk("pwrup_pll_rst_fall_edge", ev_pll_fall, 16);
    chk("pwrup_sdram_fall_edge", ev_sd_fall, 101 + 2 + 1024);
    chk("pwrup_video_fall_edge", ev_vid_fall, 101 + 2 + 1024 + 64);
    chk("pwrup_ready_edge", ev_rdy_rise, 101 + 2 + 1024 + 128);
    chk("pwrup_game_fall_edge", ev_game_fall, 101 + 2 + 1024 + 128);

    // Game reset: two 5-cycle pulses 40 cycles apart
    for (int i = 0; i < 10; i++) step();
    t_mark = cyc + 1;
    for (int i = 0; i < 150; i++) begin
      game_rst = (i < 5) || (i >= 40 && i < 45);
      step();
    end
    game_rst = 1'b0;
    chk("grst_rise_latency", ev_game_rise - t_mark, 2);
    chk("grst_stretch_len", ev_game_fall - ev_game_rise, 40 + 5 + 64);

    // Lock loss in RUN
    t_mark = cyc + 1;
    pll_locked = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("loss_ready_latency", ev_rdy_fall - t_mark, 2);
    chk("loss_pll_rst_hold", ev_pll_fall - ev_pll_rise, 16);

    // Relock, then a 3-cycle glitch in SETTLE
    pll_locked = 1'b1;
    for (int i = 0; i < 200; i++) step();
    pll_locked = 1'b0;
    for (int i = 0; i < 3; i++) step();
    t_mark = cyc + 1;
    pll_locked = 1'b1;
    for (int i = 0; i < 3000 && !ready; i++) step();
    chk("glitch_retries", int'(retries), 0);
    chk("glitch_sdram_release", ev_sd_fall - t_mark, 2 + 1024);
    chk("relock_ready", int'(ready), 1);

    // Randomized lock / game-reset traffic with one mid-run async reset
    for (int i = 0; i < 12000; i++) begin
      if (i == 6000) async_reset();
      if (pll_locked) begin
        if ($urandom_range(2999, 0) == 0) pll_locked = 1'b0;
      end else if ($urandom_range(19, 0) == 0) begin
        pll_locked = 1'b1;
      end
      if ($urandom_range(63, 0) == 0) game_rst = ~game_rst;
      step();
    end

    // Never lock
    pll_locked = 1'b0;
    game_rst   = 1'b0;
    async_reset();
`ifdef JTFRAME_PLL_WATCHDOG_EN
    for (int i = 0; i < 1000 && !fail; i++) step();
    for (int i = 0; i < 20; i++) step();
    chk("wdog_retry1_edge", ev_retry[1], 116);
    chk("wdog_retry2_edge", ev_retry[2], 232);
    chk("wdog_fail_edge", ev_fail_rise, 348);
    chk("wdog_retries_final", int'(retries), 3);
    chk("wdog_pll_rst_held", int'(pll_rst), 1);
`else
    for (int i = 0; i < 2000; i++) step();
    chk("nowdog_fail", int'(fail), 0);
    chk("nowdog_retries", int'(retries), 0);
    chk("nowdog_pll_rst_low", int'(pll_rst), 0);
    chk("nowdog_ready", int'(ready), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
